// File: rtl/thread_isn_queue.sv
// -----------------------------------------------------------------------------
// thread_isn_queue
//   Per-thread instruction queue that sits behind the 4-way thread demux.
//   Each cycle it can capture one 4-wide fetch bundle. The valid slots are
//   compacted in program order (slot1 first) into a circular buffer. The head
//   entry is presented to decode/issue with a valid/ready handshake.
//   o_Stall throttles the fetch/demux path early enough to absorb the bundle
//   that is already in flight in the demux register.
//
// Ports
//   i_Clk           clock, all state updates on the rising edge
//   i_Reset_n       asynchronous reset, active low
//   i_Flush         synchronous flush, empties the queue
//   i_Bundle        {slot1,slot2,slot3,slot4}, slot1 in the MSBs (oldest)
//   i_Bundle_valid  slot valid mask, bit3 = slot1 ... bit0 = slot4
//   o_Stall         upstream must stop sending bundles to this thread
//   o_Instruction   head entry (show-ahead), don't-care while o_Valid = 0
//   o_Valid         queue non-empty
//   i_Ready         consumer accepts o_Instruction this cycle
//   o_Count         current occupancy, 0..DEPTH
//   o_Overflow      sticky flag: a whole bundle was dropped for lack of space
// -----------------------------------------------------------------------------
module thread_isn_queue #(
    parameter int ISN_WIDTH = 99,
    parameter int DEPTH     = 16,
    parameter int PTR_W     = 4
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset_n,
    input  logic                   i_Flush,
    input  logic [4*ISN_WIDTH-1:0] i_Bundle,
    input  logic [3:0]             i_Bundle_valid,
    output logic                   o_Stall,
    output logic [ISN_WIDTH-1:0]   o_Instruction,
    output logic                   o_Valid,
    input  logic                   i_Ready,
    output logic [PTR_W:0]         o_Count,
    output logic                   o_Overflow
);

    localparam int CNT_W = PTR_W + 1;
    localparam int SLOTS = 4;
    // One bundle already registered in the demux plus the one being requested.
    localparam int STALL_HEADROOM = 2 * SLOTS;

    logic [ISN_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic                 pop;
    logic [2:0]           push_n;
    logic [CNT_W:0]       free_space;
    logic                 push_fits;
    logic                 push_accept;
    logic                 push_drop;
    logic [ISN_WIDTH-1:0] slot_data [SLOTS];
    logic [PTR_W-1:0]     slot_addr [SLOTS];
    logic [SLOTS-1:0]     slot_we;

    // Compaction: each valid slot lands at wr_ptr plus the number of valid
    // slots that precede it in program order; invalid slots take no entry.
    // NOTE: every always_comb output gets a default before any conditional
    // logic so that no path leaves it unassigned and infers a latch.
    always_comb begin
        push_n = '0;
        for (int k = 0; k < SLOTS; k++) begin
            slot_data[k] = i_Bundle[(SLOTS-k)*ISN_WIDTH-1 -: ISN_WIDTH];
            slot_addr[k] = wr_ptr_q + PTR_W'(push_n);
            push_n       = push_n + 3'(i_Bundle_valid[SLOTS-1-k]);
        end
    end

    assign o_Valid = (count_q != '0);
    assign pop     = o_Valid & i_Ready;

    // A same-cycle pop frees one entry for the incoming bundle. One extra bit
    // keeps DEPTH + 1 representable.
    assign free_space  = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + (CNT_W+1)'(pop);
    assign push_fits   = (CNT_W+1)'(push_n) <= free_space;
    assign push_accept = !i_Flush && (push_n != '0) && push_fits;
    assign push_drop   = !i_Flush && (push_n != '0) && !push_fits;

    always_comb begin
        for (int k = 0; k < SLOTS; k++) begin
            slot_we[k] = push_accept & i_Bundle_valid[SLOTS-1-k];
        end
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | push_drop;
        if (i_Flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_accept) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
            end
            count_d = count_q + (push_accept ? CNT_W'(push_n) : '0) - CNT_W'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array has no reset; contents are only observable
    // once count says an entry is valid, and leaving it unreset lets it map
    // onto plain RAM/flops without a reset tree.
    always_ff @(posedge i_Clk) begin
        for (int k = 0; k < SLOTS; k++) begin
            if (slot_we[k]) begin
                mem_q[slot_addr[k]] <= slot_data[k];
            end
        end
    end

    assign o_Instruction = mem_q[rd_ptr_q];
    assign o_Count       = count_q;
    assign o_Overflow    = overflow_q;
    // Equivalent to (DEPTH - count) < STALL_HEADROOM, from registered count only.
    assign o_Stall       = count_q > CNT_W'(DEPTH - STALL_HEADROOM);

endmodule

// File: tb/tb_thread_isn_queue.sv
// -----------------------------------------------------------------------------
// tb_thread_isn_queue
//   Self-checking bench for thread_isn_queue. A queue-based reference model
//   tracks the expected contents, occupancy and sticky overflow flag; outputs
//   are compared on the falling edge after each rising edge.
// -----------------------------------------------------------------------------
module tb_thread_isn_queue;

    localparam int W     = 99;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic             i_Clk;
    logic             i_Reset_n;
    logic             i_Flush;
    logic [4*W-1:0]   i_Bundle;
    logic [3:0]       i_Bundle_valid;
    logic             o_Stall;
    logic [W-1:0]     o_Instruction;
    logic             o_Valid;
    logic             i_Ready;
    logic [PTR_W:0]   o_Count;
    logic             o_Overflow;

    thread_isn_queue #(
        .ISN_WIDTH (W),
        .DEPTH     (DEPTH),
        .PTR_W     (PTR_W)
    ) dut (
        .i_Clk          (i_Clk),
        .i_Reset_n      (i_Reset_n),
        .i_Flush        (i_Flush),
        .i_Bundle       (i_Bundle),
        .i_Bundle_valid (i_Bundle_valid),
        .o_Stall        (o_Stall),
        .o_Instruction  (o_Instruction),
        .o_Valid        (o_Valid),
        .i_Ready        (i_Ready),
        .o_Count        (o_Count),
        .o_Overflow     (o_Overflow)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] model_q [$];
    bit           model_ovf = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_isn();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    function automatic logic [4*W-1:0] rand_bundle();
        return {rand_isn(), rand_isn(), rand_isn(), rand_isn()};
    endfunction

    task automatic check_outputs(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ".valid"}, 128'(o_Valid), 128'(sz != 0));
        check({tag, ".count"}, 128'(o_Count), 128'(sz));
        check({tag, ".stall"}, 128'(o_Stall), 128'((DEPTH - sz) < 8));
        check({tag, ".ovf"},   128'(o_Overflow), 128'(model_ovf));
        if (sz != 0) begin
            check({tag, ".head"}, 128'(o_Instruction), 128'(model_q[0]));
        end
    endtask

    // Called just after a falling edge: drive, update model, clock, compare.
    task automatic step(input string tag, input logic flush, input logic [3:0] mask,
                        input logic ready, input logic [4*W-1:0] bundle);
        int n;
        bit do_pop;
        i_Flush        = flush;
        i_Bundle_valid = mask;
        i_Ready        = ready;
        i_Bundle       = bundle;

        do_pop = (model_q.size() != 0) && ready;
        n      = $countones(mask);
        if (flush) begin
            model_q.delete();
        end else begin
            bit take;
            take = 1'b0;
            if (n != 0) begin
                if (n <= DEPTH - model_q.size() + int'(do_pop)) take = 1'b1;
                else model_ovf = 1'b1;
            end
            if (do_pop) void'(model_q.pop_front());
            if (take) begin
                for (int s = 0; s < 4; s++) begin
                    if (mask[3-s]) model_q.push_back(bundle[(4-s)*W-1 -: W]);
                end
            end
        end

        @(posedge i_Clk);
        @(negedge i_Clk);
        check_outputs(tag);
    endtask

    logic [4*W-1:0] b;
    logic [W-1:0]   isn_a, isn_b, isn_c, isn_d, isn_e, isn_g;

    initial begin
        i_Reset_n      = 1'b0;
        i_Flush        = 1'b0;
        i_Bundle       = rand_bundle();
        i_Bundle_valid = 4'b1111;
        i_Ready        = 1'b0;

        // Reset held with a full mask and the clock running.
        repeat (3) @(negedge i_Clk);
        check("rst.valid", 128'(o_Valid), 128'(0));
        check("rst.count", 128'(o_Count), 128'(0));
        check("rst.stall", 128'(o_Stall), 128'(0));
        check("rst.ovf",   128'(o_Overflow), 128'(0));
        i_Reset_n = 1'b1;

        // In-order pop of A,B,C,D.
        b = rand_bundle();
        isn_a = b[4*W-1 -: W]; isn_b = b[3*W-1 -: W];
        isn_c = b[2*W-1 -: W]; isn_d = b[W-1:0];
        step("push_abcd", 1'b0, 4'b1111, 1'b0, b);
        check("abcd.count", 128'(o_Count), 128'(4));
        check("abcd.head",  128'(o_Instruction), 128'(isn_a));
        step("pop_a", 1'b0, 4'b0000, 1'b1, rand_bundle());
        check("pop_a.head", 128'(o_Instruction), 128'(isn_b));
        step("pop_b", 1'b0, 4'b0000, 1'b1, rand_bundle());
        check("pop_b.head", 128'(o_Instruction), 128'(isn_c));
        step("pop_c", 1'b0, 4'b0000, 1'b1, rand_bundle());
        check("pop_c.head", 128'(o_Instruction), 128'(isn_d));
        step("pop_d", 1'b0, 4'b0000, 1'b1, rand_bundle());
        check("pop_d.valid", 128'(o_Valid), 128'(0));

        // Compaction with mask 1010, then an empty mask.
        b = rand_bundle();
        isn_e = b[4*W-1 -: W]; isn_g = b[2*W-1 -: W];
        step("push_1010", 1'b0, 4'b1010, 1'b0, b);
        check("cmp.count", 128'(o_Count), 128'(2));
        check("cmp.head_e", 128'(o_Instruction), 128'(isn_e));
        step("mask0", 1'b0, 4'b0000, 1'b0, rand_bundle());
        check("mask0.count", 128'(o_Count), 128'(2));
        step("pop_e", 1'b0, 4'b0000, 1'b1, rand_bundle());
        check("cmp.head_g", 128'(o_Instruction), 128'(isn_g));
        step("pop_g", 1'b0, 4'b0000, 1'b1, rand_bundle());

        // Stall threshold and overflow.
        step("fill4", 1'b0, 4'b1111, 1'b0, rand_bundle());
        step("fill8", 1'b0, 4'b1111, 1'b0, rand_bundle());
        check("cnt8.stall", 128'(o_Stall), 128'(0));
        step("fill9", 1'b0, 4'b0001, 1'b0, rand_bundle());
        check("cnt9.stall", 128'(o_Stall), 128'(1));
        step("fill13", 1'b0, 4'b1111, 1'b0, rand_bundle());
        step("fill14", 1'b0, 4'b0100, 1'b0, rand_bundle());
        check("cnt14.ovf_before", 128'(o_Overflow), 128'(0));
        step("drop", 1'b0, 4'b1111, 1'b0, rand_bundle());
        check("drop.count", 128'(o_Count), 128'(14));
        check("drop.ovf",   128'(o_Overflow), 128'(1));
        step("to13", 1'b0, 4'b0000, 1'b1, rand_bundle());
        step("push_pop_full", 1'b0, 4'b1111, 1'b1, rand_bundle());
        check("full.count", 128'(o_Count), 128'(16));

        // Simultaneous push/pop at count 5.
        repeat (11) step("drain5", 1'b0, 4'b0000, 1'b1, rand_bundle());
        check("cnt5.count", 128'(o_Count), 128'(5));
        step("push_pop5", 1'b0, 4'b1111, 1'b1, rand_bundle());
        check("pp5.count", 128'(o_Count), 128'(8));

        // Random streaming across pointer wrap.
        for (int i = 0; i < 60; i++) begin
            step("stream", 1'b0, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0), rand_bundle());
        end

        // Flush at count 6 with concurrent push and pop.
        repeat (DEPTH + 1) step("drain", 1'b0, 4'b0000, 1'b1, rand_bundle());
        check("drained.count", 128'(o_Count), 128'(0));
        step("f_push4", 1'b0, 4'b1111, 1'b0, rand_bundle());
        step("f_push2", 1'b0, 4'b0011, 1'b0, rand_bundle());
        check("f6.count", 128'(o_Count), 128'(6));
        step("flush", 1'b1, 4'b1111, 1'b1, rand_bundle());
        check("flush.count", 128'(o_Count), 128'(0));
        check("flush.valid", 128'(o_Valid), 128'(0));
        check("flush.ovf",   128'(o_Overflow), 128'(1));

        // Asynchronous reset mid-operation, away from any clock edge.
        step("pre_rst", 1'b0, 4'b1111, 1'b0, rand_bundle());
        #2 i_Reset_n = 1'b0;
        #1;
        check("arst.count", 128'(o_Count), 128'(0));
        check("arst.valid", 128'(o_Valid), 128'(0));
        check("arst.ovf",   128'(o_Overflow), 128'(0));
        model_q.delete();
        model_ovf = 1'b0;
        @(negedge i_Clk);
        i_Reset_n = 1'b1;
        step("post_rst", 1'b0, 4'b1111, 1'b0, rand_bundle());

        // Random traffic with occasional flushes.
        for (int i = 0; i < 50; i++) begin
            step("rand_flush", 1'($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), rand_bundle());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
